// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the LSU data path.
// Data wins ties; a streak counter forces a fetch grant after STREAK_MAX back-to-back data grants.
module mem_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned STREAK_W   = 3
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            ins_req_valid_in,
  input  logic [XLEN-1:0] ins_req_addr_in,
  output logic            ins_req_ready_out,
  output logic [XLEN-1:0] ins_req_data_out,
  input  logic            data_req_valid_in,
  input  logic            data_req_write_in,
  input  logic [XLEN-1:0] data_req_addr_in,
  input  logic [XLEN-1:0] data_req_data_in,
  output logic            data_req_ready_out,
  output logic [XLEN-1:0] data_req_data_out,
  output logic            mem_valid_out,
  output logic            mem_write_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_data_out,
  input  logic            mem_ready_in,
  input  logic [XLEN-1:0] mem_data_in,
  output logic            arb_busy_out,
  output logic            arb_owner_out
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE,
    INS_ACC,
    DATA_ACC,
    RESP
  } state_t;

  state_t              state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                grant_ins, grant_data;
  logic                access_done;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    grant_ins   = 1'b0;
    grant_data  = 1'b0;
    access_done = 1'b0;
    case (state)
      IDLE: begin
        if (data_req_valid_in && (!ins_req_valid_in || streak < STREAK_LIMIT)) begin
          grant_data = 1'b1;
          state_nxt  = DATA_ACC;
        end else if (ins_req_valid_in) begin
          grant_ins = 1'b1;
          state_nxt = INS_ACC;
        end
        // Streak only counts data grants that actually held off a pending fetch.
        if (!ins_req_valid_in || grant_ins) begin
          streak_nxt = '0;
        end else if (grant_data && streak < STREAK_LIMIT) begin
          streak_nxt = streak + STREAK_W'(1);
        end
      end
      INS_ACC, DATA_ACC: begin
        if (mem_ready_in) begin
          access_done = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      ins_req_ready_out  <= 1'b0;
      ins_req_data_out   <= '0;
      data_req_ready_out <= 1'b0;
      data_req_data_out  <= '0;
      mem_valid_out      <= 1'b0;
      mem_write_out      <= 1'b0;
      mem_addr_out       <= '0;
      mem_data_out       <= '0;
      arb_busy_out       <= 1'b0;
      arb_owner_out      <= 1'b0;
    end else begin
      ins_req_ready_out  <= 1'b0;
      data_req_ready_out <= 1'b0;
      arb_busy_out       <= (state_nxt != IDLE);
      if (grant_data) begin
        mem_valid_out <= 1'b1;
        mem_write_out <= data_req_write_in;
        mem_addr_out  <= data_req_addr_in;
        mem_data_out  <= data_req_data_in;
        arb_owner_out <= 1'b1;
      end else if (grant_ins) begin
        mem_valid_out <= 1'b1;
        mem_write_out <= 1'b0;
        mem_addr_out  <= ins_req_addr_in;
        mem_data_out  <= '0;
        arb_owner_out <= 1'b0;
      end
      if (access_done) begin
        mem_valid_out <= 1'b0;
        if (state == DATA_ACC) begin
          data_req_data_out  <= mem_data_in;
          data_req_ready_out <= 1'b1;
        end else begin
          ins_req_data_out  <= mem_data_in;
          ins_req_ready_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/store/load paths, priority, streak limit, stall, async reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_valid;
  logic [31:0] ins_addr;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic        d_valid;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        busy;
  logic        owner;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  mem_port_arbiter #(.XLEN(32), .STREAK_MAX(4), .STREAK_W(3)) dut (
    .clock_in          (clk),
    .reset_in          (rst_n),
    .ins_req_valid_in  (ins_valid),
    .ins_req_addr_in   (ins_addr),
    .ins_req_ready_out (ins_ready),
    .ins_req_data_out  (ins_data),
    .data_req_valid_in (d_valid),
    .data_req_write_in (d_write),
    .data_req_addr_in  (d_addr),
    .data_req_data_in  (d_wdata),
    .data_req_ready_out(d_ready),
    .data_req_data_out (d_rdata),
    .mem_valid_out     (m_valid),
    .mem_write_out     (m_write),
    .mem_addr_out      (m_addr),
    .mem_data_out      (m_wdata),
    .mem_ready_in      (m_ready),
    .mem_data_in       (m_rdata),
    .arb_busy_out      (busy),
    .arb_owner_out     (owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ins_valid = 1'b0;
    ins_addr  = '0;
    d_valid   = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    tick();
    tick();
    check("rst_mem_valid", 32'(m_valid), 32'd0);
    check("rst_busy",      32'(busy),    32'd0);
    check("rst_owner",     32'(owner),   32'd0);
    check("rst_ins_ready", 32'(ins_ready), 32'd0);
    check("rst_d_ready",   32'(d_ready), 32'd0);
    check("rst_m_addr",    m_addr,       32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch only, memory ready two cycles after mem_valid rises.
    ins_valid = 1'b1;
    ins_addr  = 32'h100;
    tick();
    check("f_mem_valid", 32'(m_valid), 32'd1);
    check("f_mem_addr",  m_addr,       32'h100);
    check("f_mem_write", 32'(m_write), 32'd0);
    check("f_owner",     32'(owner),   32'd0);
    check("f_busy",      32'(busy),    32'd1);
    tick();
    check("f_wait_valid", 32'(m_valid), 32'd1);
    check("f_wait_ready", 32'(ins_ready), 32'd0);
    m_ready = 1'b1;
    m_rdata = 32'h0000_0013;
    tick();
    check("f_ins_ready", 32'(ins_ready), 32'd1);
    check("f_ins_data",  ins_data,       32'h0000_0013);
    check("f_mem_drop",  32'(m_valid),   32'd0);
    check("f_d_ready",   32'(d_ready),   32'd0);
    ins_valid = 1'b0;
    m_ready   = 1'b0;
    tick();
    check("f_ready_clr", 32'(ins_ready), 32'd0);
    check("f_idle_busy", 32'(busy),      32'd0);
    check("f_data_hold", ins_data,       32'h0000_0013);

    // Store with zero-wait memory; mem_ready high during IDLE must be ignored.
    d_valid = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h2000;
    d_wdata = 32'hDEAD_BEEF;
    m_ready = 1'b1;
    m_rdata = 32'h55AA_55AA;
    tick();
    check("s_mem_valid", 32'(m_valid), 32'd1);
    check("s_mem_write", 32'(m_write), 32'd1);
    check("s_mem_addr",  m_addr,       32'h2000);
    check("s_mem_data",  m_wdata,      32'hDEAD_BEEF);
    check("s_owner",     32'(owner),   32'd1);
    check("s_early_rdy", 32'(d_ready), 32'd0);
    tick();
    check("s_d_ready",   32'(d_ready),   32'd1);
    check("s_d_rdata",   d_rdata,        32'h55AA_55AA);
    check("s_ins_ready", 32'(ins_ready), 32'd0);
    d_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    check("s_ready_clr", 32'(d_ready), 32'd0);
    check("s_ins_hold",  ins_data,     32'h0000_0013);

    // Both request together with streak 0: data first, then fetch.
    ins_valid = 1'b1;
    ins_addr  = 32'h104;
    d_valid   = 1'b1;
    d_write   = 1'b0;
    d_addr    = 32'h3000;
    m_ready   = 1'b1;
    m_rdata   = 32'h1111_1111;
    tick();
    check("b_owner_d", 32'(owner),   32'd1);
    check("b_addr_d",  m_addr,       32'h3000);
    check("b_write_d", 32'(m_write), 32'd0);
    tick();
    check("b_d_ready",  32'(d_ready),   32'd1);
    check("b_d_rdata",  d_rdata,        32'h1111_1111);
    check("b_no_iready", 32'(ins_ready), 32'd0);
    d_valid = 1'b0;
    m_rdata = 32'h2222_2222;
    tick();
    tick();
    check("b_owner_i", 32'(owner),   32'd0);
    check("b_addr_i",  m_addr,       32'h104);
    check("b_wdata_i", m_wdata,      32'd0);
    check("b_write_i", 32'(m_write), 32'd0);
    tick();
    check("b_i_ready", 32'(ins_ready), 32'd1);
    check("b_i_data",  ins_data,       32'h2222_2222);
    check("b_d_hold",  d_rdata,        32'h1111_1111);
    ins_valid = 1'b0;
    tick();

    // Fetch held pending while data re-requests continuously: D,D,D,D,I.
    ins_valid = 1'b1;
    ins_addr  = 32'h200;
    d_valid   = 1'b1;
    d_addr    = 32'h5000;
    m_ready   = 1'b1;
    for (int unsigned g = 0; g < 5; g++) begin
      m_rdata = 32'hA0 + g;
      tick();
      check($sformatf("st_owner%0d", g), 32'(owner), (g < 4) ? 32'd1 : 32'd0);
      check($sformatf("st_addr%0d", g),  m_addr,     (g < 4) ? 32'h5000 : 32'h200);
      tick();
      if (g < 4) begin
        check($sformatf("st_dready%0d", g), 32'(d_ready), 32'd1);
        check($sformatf("st_drdata%0d", g), d_rdata,      32'hA0 + g);
      end else begin
        check("st_iready", 32'(ins_ready), 32'd1);
        check("st_idata",  ins_data,       32'hA4);
        check("st_no_dready", 32'(d_ready), 32'd0);
      end
      tick();
    end
    // Streak cleared by the fetch grant: next tie goes to data again.
    tick();
    check("st_after_owner", 32'(owner), 32'd1);
    ins_valid = 1'b0;
    d_valid   = 1'b0;
    tick();
    check("st_after_dready", 32'(d_ready), 32'd1);
    tick();
    check("st_after_idle", 32'(busy), 32'd0);

    // Memory stalls for 20 cycles; requester inputs wiggle and must be ignored.
    d_valid = 1'b1;
    d_write = 1'b0;
    d_addr  = 32'h4000;
    d_wdata = 32'h0;
    m_ready = 1'b0;
    m_rdata = 32'h7777_7777;
    tick();
    for (int unsigned c = 0; c < 20; c++) begin
      ins_valid = c[0];
      ins_addr  = 32'h900 + c;
      d_addr    = 32'h4000 + c;
      tick();
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_addr",  m_addr,       32'h4000);
      check("stall_busy",  32'(busy),    32'd1);
      check("stall_ready", 32'(d_ready | ins_ready), 32'd0);
    end

    // Asynchronous reset in the middle of the stalled data access.
    ins_valid = 1'b0;
    d_valid   = 1'b0;
    rst_n     = 1'b0;
    #2;
    check("ar_mem_valid", 32'(m_valid), 32'd0);
    check("ar_busy",      32'(busy),    32'd0);
    check("ar_owner",     32'(owner),   32'd0);
    check("ar_m_addr",    m_addr,       32'd0);
    check("ar_d_rdata",   d_rdata,      32'd0);
    check("ar_i_data",    ins_data,     32'd0);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    check("ar_post_dready", 32'(d_ready), 32'd0);
    check("ar_post_valid",  32'(m_valid), 32'd0);
    tick();
    check("ar_post_dready2", 32'(d_ready), 32'd0);
    check("ar_post_busy",    32'(busy),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
